// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions and the TX state encoding.
package uart_pkg;

   localparam logic [31:0] UART_TXDATA_OFF = 32'h0000_0000;
   localparam logic [31:0] UART_STATUS_OFF = 32'h0000_0004;
   localparam logic [31:0] UART_BAUD_OFF   = 32'h0000_0008;

   localparam int ST_FULL_BIT  = 0;
   localparam int ST_EMPTY_BIT = 1;
   localparam int ST_BUSY_BIT  = 2;
   localparam int ST_OVF_BIT   = 3;
   localparam int ST_COUNT_LSB = 4;

   localparam logic [15:0] UART_MIN_DIV = 16'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // A divisor of 0 or 1 cannot produce a bit period, so it is raised to the minimum.
   function automatic logic [15:0] clamp_div(input logic [15:0] div);
      return (div < UART_MIN_DIV) ? UART_MIN_DIV : div;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read; pushes into a full FIFO
// and pops from an empty one are ignored internally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == DEPTH_W);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV registers on the
// data bus, a byte FIFO and the serialiser FSM driving tx.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FFE0,
   parameter int          FIFO_DEPTH  = 8,
   parameter int          DEFAULT_DIV = 52
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        write_mem,
   input  logic [2:0]  funct3,
   input  logic [31:0] write_address,
   input  logic [31:0] write_data,
   input  logic [31:0] read_address,
   output logic [31:0] read_data,
   output logic        tx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          wr_txdata, wr_status, wr_baud;
   logic          fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;

   uart_state_t   state_q, state_d;
   logic [15:0]   baud_div_q, baud_div_d;
   logic [15:0]   div_lat_q, div_lat_d;
   logic [15:0]   bit_cnt_q, bit_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   read_q, read_d;
   logic [31:0]   status_word;
   logic [3:0]    count_sat;
   logic          load_frame;

   // Only byte lane 0 and the low half-word of the bus data are meaningful here.
   logic unused_bits;
   assign unused_bits = ^{funct3, write_data[31:16]};

   assign wr_txdata = write_mem && (write_address == BASE_ADDR + UART_TXDATA_OFF);
   assign wr_status = write_mem && (write_address == BASE_ADDR + UART_STATUS_OFF);
   assign wr_baud   = write_mem && (write_address == BASE_ADDR + UART_BAUD_OFF);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr_txdata),
      .pop   (fifo_pop),
      .din   (write_data[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Register file: divisor and sticky overflow.
   always_comb begin
      baud_div_d = baud_div_q;
      ovf_d      = ovf_q;
      if (wr_baud) begin
         baud_div_d = clamp_div(write_data[15:0]);
      end
      if (wr_txdata && fifo_full) begin
         ovf_d = 1'b1;
      end else if (wr_status && write_data[ST_OVF_BIT]) begin
         ovf_d = 1'b0;
      end
   end

   // TX serialiser; the divisor is latched per frame so mid-frame writes wait.
   always_comb begin
      state_d    = state_q;
      div_lat_d  = div_lat_q;
      bit_cnt_d  = bit_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      fifo_pop   = 1'b0;
      load_frame = 1'b0;
      case (state_q)
         IDLE: begin
            load_frame = !fifo_empty;
         end
         START: begin
            if (bit_cnt_q == '0) begin
               state_d   = DATA;
               tx_d      = shift_q[0];
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = 3'd0;
               bit_cnt_d = div_lat_q - 16'd1;
            end else begin
               bit_cnt_d = bit_cnt_q - 16'd1;
            end
         end
         DATA: begin
            if (bit_cnt_q == '0) begin
               bit_cnt_d = div_lat_q - 16'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shift_q[0];
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end else begin
               bit_cnt_d = bit_cnt_q - 16'd1;
            end
         end
         STOP: begin
            if (bit_cnt_q == '0) begin
               if (fifo_empty) begin
                  state_d = IDLE;
               end else begin
                  load_frame = 1'b1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
      if (load_frame) begin
         fifo_pop  = 1'b1;
         state_d   = START;
         shift_d   = fifo_dout;
         div_lat_d = baud_div_q;
         bit_cnt_d = baud_div_q - 16'd1;
         tx_d      = 1'b0;
      end
   end

   // STATUS image and registered read mux.
   always_comb begin
      if (32'(fifo_count) > 32'd15) begin
         count_sat = 4'hF;
      end else begin
         count_sat = 4'(fifo_count);
      end
      status_word                        = '0;
      status_word[ST_FULL_BIT]           = fifo_full;
      status_word[ST_EMPTY_BIT]          = fifo_empty;
      status_word[ST_BUSY_BIT]           = (state_q != IDLE);
      status_word[ST_OVF_BIT]            = ovf_q;
      status_word[ST_COUNT_LSB +: 4]     = count_sat;

      read_d = '0;
      if (read_address == BASE_ADDR + UART_STATUS_OFF) begin
         read_d = status_word;
      end else if (read_address == BASE_ADDR + UART_BAUD_OFF) begin
         read_d = {16'h0000, baud_div_q};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         baud_div_q <= 16'(DEFAULT_DIV);
         div_lat_q  <= 16'(DEFAULT_DIV);
         bit_cnt_q  <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         ovf_q      <= 1'b0;
         read_q     <= '0;
      end else begin
         state_q    <= state_d;
         baud_div_q <= baud_div_d;
         div_lat_q  <= div_lat_d;
         bit_cnt_q  <= bit_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         ovf_q      <= ovf_d;
         read_q     <= read_d;
      end
   end

   assign tx        = tx_q;
   assign read_data = read_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a serial-line monitor decodes frames and checks them
// against a queue of expected bytes; bus reads are checked inline per scenario.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'hFFFF_FFE0;
   localparam logic [31:0] A_TXD = BASE;
   localparam logic [31:0] A_STA = BASE + 32'd4;
   localparam logic [31:0] A_BAU = BASE + 32'd8;
   localparam logic [31:0] A_RSV = BASE + 32'd12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        write_mem = 1'b0;
   logic [2:0]  funct3 = 3'b010;
   logic [31:0] write_address = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_address = '0;
   logic [31:0] read_data;
   logic        tx;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_cyc = 0;
   int tb_div = 52;
   bit in_frame = 1'b0;
   logic [7:0] sb[$];
   int frame_starts[$];

   mmio_uart_tx #(
      .BASE_ADDR   (BASE),
      .FIFO_DEPTH  (8),
      .DEFAULT_DIV (52)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .write_mem     (write_mem),
      .funct3        (funct3),
      .write_address (write_address),
      .write_data    (write_data),
      .read_address  (read_address),
      .read_data     (read_data),
      .tx            (tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- serial monitor ----------------
   task automatic mon_frame();
      int d;
      logic [9:0] bits;
      logic v;
      bit ok;
      logic [7:0] got;
      logic [7:0] exp;
      d = tb_div;
      ok = 1'b1;
      bits = '0;
      in_frame = 1'b1;
      frame_starts.push_back(cyc);
      for (int b = 0; b < 10; b++) begin
         for (int k = 0; k < d; k++) begin
            if (!(b == 0 && k == 0)) begin
               @(negedge clk);
               if (!rst_n) begin
                  in_frame = 1'b0;
                  return;
               end
            end
            v = tx;
            if (k == 0) bits[b] = v;
            else if (v !== bits[b]) ok = 1'b0;
         end
      end
      in_frame = 1'b0;
      got = bits[8:1];
      checks++;
      if (!ok || bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
         errors++;
         $display("FAIL frame_shape: got bits %b (stable=%0d) required start 0, stop 1, each bit %0d cycles",
                  bits, ok, d);
      end
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL frame_unexpected: got byte %h required no frame", got);
      end else begin
         exp = sb.pop_front();
         if (got !== exp) begin
            errors++;
            $display("FAIL frame_byte: got %h required %h", got, exp);
         end else begin
            $display("frame: byte %h at cycle %0d, div %0d", got, frame_starts[frame_starts.size()-1], d);
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && tx === 1'b0) mon_frame();
      end
   end

   // ---------------- bus helpers ----------------
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      write_mem = 1'b1;
      write_address = a;
      write_data = d;
      @(posedge clk);
      #1;
      write_mem = 1'b0;
      wr_cyc = cyc;
      $display("write: addr %h data %h", a, d);
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      read_address = a;
      @(posedge clk);
      #1;
      d = read_data;
      $display("read: addr %h data %h", a, d);
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while ((sb.size() != 0 || in_frame) && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= max_cycles) begin
         errors++;
         $display("FAIL wait_idle: got %0d bytes still pending after %0d cycles required 0", sb.size(), n);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] d;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
      checks++;
      if (read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h required 0", read_data); end
      @(negedge clk);
      rst_n = 1'b1;
      bus_read(A_STA, d);
      checks++;
      if (d !== 32'h0000_0002) begin errors++; $display("FAIL reset_status: got %h required 00000002", d); end
      bus_read(A_BAU, d);
      checks++;
      if (d !== 32'd52) begin errors++; $display("FAIL reset_baud: got %0d required 52", d); end
   endtask

   task automatic test_single_byte();
      logic [31:0] d;
      int idx;
      bus_write(A_BAU, 32'd4);
      tb_div = 4;
      idx = frame_starts.size();
      sb.push_back(8'h55);
      bus_write(A_TXD, 32'h0000_0055);
      repeat (3) @(negedge clk);
      bus_read(A_STA, d);
      checks++;
      if (d !== 32'h0000_0006) begin errors++; $display("FAIL single_busy: got %h required 00000006", d); end
      wait_idle(200);
      checks++;
      if (frame_starts.size() <= idx || frame_starts[idx] - wr_cyc != 1) begin
         errors++;
         $display("FAIL single_latency: got %0d frames since write, first start %0d cycles after write edge required 1",
                  frame_starts.size() - idx, (frame_starts.size() > idx) ? frame_starts[idx] - wr_cyc : -1);
      end
      bus_read(A_STA, d);
      checks++;
      if (d !== 32'h0000_0002) begin errors++; $display("FAIL single_idle: got %h required 00000002", d); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      int idx;
      idx = frame_starts.size();
      sb.push_back(8'hA5);
      sb.push_back(8'h3C);
      bus_write(A_TXD, 32'h0000_00A5);
      bus_write(A_TXD, 32'h0000_003C);
      bus_read(A_STA, d);
      checks++;
      if (d !== 32'h0000_0014) begin errors++; $display("FAIL b2b_status: got %h required 00000014", d); end
      wait_idle(300);
      checks++;
      if (frame_starts.size() < idx + 2 || frame_starts[idx+1] - frame_starts[idx] != 40) begin
         errors++;
         $display("FAIL b2b_gap: got %0d frames, spacing %0d required 2 frames spaced 40",
                  frame_starts.size() - idx,
                  (frame_starts.size() >= idx + 2) ? frame_starts[idx+1] - frame_starts[idx] : -1);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      for (int i = 0; i < 10; i++) begin
         if (i < 9) sb.push_back(8'h10 + 8'(i));
      end
      for (int i = 0; i < 10; i++) begin
         bus_write(A_TXD, 32'h10 + 32'(i));
      end
      bus_read(A_STA, d);
      checks++;
      if (d !== 32'h0000_008D) begin errors++; $display("FAIL ovf_status: got %h required 0000008D", d); end
      bus_write(A_STA, 32'h0000_0007);
      bus_read(A_STA, d);
      checks++;
      if (d !== 32'h0000_008D) begin errors++; $display("FAIL ovf_keep: got %h required 0000008D", d); end
      bus_write(A_STA, 32'h0000_0008);
      bus_read(A_STA, d);
      checks++;
      if (d !== 32'h0000_0085) begin errors++; $display("FAIL ovf_clear: got %h required 00000085", d); end
      wait_idle(1000);
   endtask

   task automatic test_divisor();
      logic [31:0] d;
      int idx;
      bus_write(A_BAU, 32'd0);
      bus_read(A_BAU, d);
      checks++;
      if (d !== 32'd2) begin errors++; $display("FAIL div_clamp0: got %0d required 2", d); end
      bus_write(A_BAU, 32'h0001_0007);
      bus_read(A_BAU, d);
      checks++;
      if (d !== 32'd7) begin errors++; $display("FAIL div_upper: got %0d required 7", d); end
      bus_write(A_BAU, 32'd1);
      bus_read(A_BAU, d);
      checks++;
      if (d !== 32'd2) begin errors++; $display("FAIL div_clamp1: got %0d required 2", d); end
      tb_div = 2;
      idx = frame_starts.size();
      sb.push_back(8'hC3);
      bus_write(A_TXD, 32'h0000_00C3);
      repeat (5) @(negedge clk);
      bus_write(A_BAU, 32'd10);
      tb_div = 10;
      bus_read(A_BAU, d);
      checks++;
      if (d !== 32'd10) begin errors++; $display("FAIL div_write10: got %0d required 10", d); end
      sb.push_back(8'h81);
      bus_write(A_TXD, 32'h0000_0081);
      wait_idle(400);
      checks++;
      if (frame_starts.size() < idx + 2 || frame_starts[idx+1] - frame_starts[idx] != 20) begin
         errors++;
         $display("FAIL div_midframe: got %0d frames, spacing %0d required 2 frames spaced 20",
                  frame_starts.size() - idx,
                  (frame_starts.size() >= idx + 2) ? frame_starts[idx+1] - frame_starts[idx] : -1);
      end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] d;
      int n0;
      bus_write(A_TXD, 32'h0000_0000);
      bus_write(A_TXD, 32'h0000_00F0);
      repeat (25) @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin errors++; $display("FAIL rst_pre_tx: got %b required 0 in DATA", tx); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL rst_async_tx: got %b required 1", tx); end
      repeat (3) @(negedge clk);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      tb_div = 52;
      n0 = frame_starts.size();
      bus_read(A_STA, d);
      checks++;
      if (d !== 32'h0000_0002) begin errors++; $display("FAIL rst_status: got %h required 00000002", d); end
      bus_read(A_BAU, d);
      checks++;
      if (d !== 32'd52) begin errors++; $display("FAIL rst_baud: got %0d required 52", d); end
      repeat (20) @(negedge clk);
      checks++;
      if (frame_starts.size() != n0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL rst_quiet: got %0d new frames, tx %b required 0 frames, tx 1", frame_starts.size() - n0, tx);
      end
   endtask

   task automatic test_decode();
      logic [31:0] d;
      int n0;
      bus_read(A_BAU, d);
      bus_read(32'h0000_1000, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL dec_outside: got %h required 0", d); end
      bus_read(A_BAU, d);
      bus_read(A_RSV, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL dec_reserved: got %h required 0", d); end
      bus_read(A_BAU, d);
      bus_read(A_TXD, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL dec_txdata_read: got %h required 0", d); end
      n0 = frame_starts.size();
      bus_write(A_RSV, 32'h0000_00FF);
      bus_write(32'h0000_1000, 32'h0000_0041);
      bus_write(BASE + 32'd1, 32'h0000_0042);
      bus_read(A_STA, d);
      checks++;
      if (d !== 32'h0000_0002) begin errors++; $display("FAIL dec_no_push: got %h required 00000002", d); end
      bus_read(A_BAU, d);
      checks++;
      if (d !== 32'd52) begin errors++; $display("FAIL dec_baud_kept: got %0d required 52", d); end
      repeat (10) @(negedge clk);
      checks++;
      if (frame_starts.size() != n0) begin
         errors++;
         $display("FAIL dec_no_frame: got %0d frames required 0", frame_starts.size() - n0);
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_overflow();
      test_divisor();
      test_reset_midframe();
      test_decode();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout at cycle %0d required completion", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that responds to the RISC-V core's data-memory bus, alongside the main memory and LED/RGB outputs. The core writes bytes into an internal FIFO, and the block serialises them onto a single `tx` pin as 8N1 frames. It also provides a status register and a programmable baud divisor. Read data is zero outside the block's address window, so top-level logic can OR it with the memory's read data.

## Interface
Parameters:
- `BASE_ADDR`, 32'hFFFF_FFE0: word-aligned base of the 3-register window.
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of two, at least 2.
- `DEFAULT_DIV`, 52: reset baud divisor (6 MHz / 115200).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `write_mem`  in  1: bus write strobe.
- `funct3`  in  3: bus access size; ignored for data, since only byte lane 0 is used.
- `write_address`  in  32: bus write address.
- `write_data`  in  32: bus write data.
- `read_address`  in  32: bus read address.
- `read_data`  out  32: registered read data; 0 when the address is outside the window.
- `tx`  out  1: serial output, idle high.

## Operation
Register map (offset from `BASE_ADDR`):
- +0 TXDATA:
  - W: push `write_data[7:0]` into the FIFO.
  - R: returns 0.
- +4 STATUS (R):
  - bit0: full.
  - bit1: empty.
  - bit2: busy (FSM not IDLE).
  - bit3: overflow (sticky).
  - bits[7:4]: FIFO count, saturating at 15.
  - Other bits read 0.
  - W: writing 1 to bit3 clears overflow; other bits are ignored.
- +8 BAUDDIV:
  - RW, bits[15:0]; upper bits read 0.
  - A written value below 2 is stored as 2.

Writes and reads to other addresses (including +12 and above, or outside the window) have no effect.

FIFO push rules:
- A push is accepted only if the registered count < `FIFO_DEPTH`.
- When full, the push is dropped and overflow is set, even if a pop occurs in the same cycle.

FSM states: IDLE, START, DATA, STOP.
- IDLE → START when the FIFO is non-empty:
  - pop the head byte into the shift register;
  - latch BAUDDIV into the bit-period counter;
  - drive `tx` = 0.
- START → DATA after DIV cycles; shift out LSB first, with a bit counter of 0..7.
- DATA → STOP after the 8th bit's DIV cycles; drive `tx` = 1.
- STOP → START directly if the FIFO is non-empty (no idle gap), otherwise STOP → IDLE.
- A BAUDDIV write mid-frame takes effect at the next frame's START.

Reset values:
- `tx` = 1, `read_data` = 0.
- FIFO empty, overflow = 0.
- BAUDDIV = `DEFAULT_DIV`, FSM = IDLE.

Asserting `rst_n` mid-frame forces `tx` high immediately (asynchronously) and discards the FIFO contents.

## Timing
- Read latency: `read_data` is valid at the rising edge after `read_address` is presented, matching main memory.
- A STATUS read reflects state as of the sampling edge.
- Write to TXDATA at edge E: count increments after E. If the FSM is IDLE, it pops at E+1 and `tx` falls after E+1.
- Each bit lasts exactly DIV cycles; a full frame is 10·DIV cycles.
- Back-to-back bytes produce a continuous stream: the STOP bit is followed by the next START with no extra cycle.
- Bit period uses a down-counter loaded with DIV−1; the bit advances when the counter reaches 0.
- Simultaneous push and pop, when not full, leaves the count unchanged and preserves FIFO order.
- FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap modulo the depth. The count is log2+1 bits.

## Structure
- Package `uart_pkg`:
  - register offsets: `UART_TXDATA_OFF`, `UART_STATUS_OFF`, `UART_BAUD_OFF`;
  - STATUS bit indices;
  - `uart_state_t` enum {IDLE, START, DATA, STOP};
  - `UART_MIN_DIV` = 2.
- Sub-module `sync_fifo`:
  - parameters: width 8, depth `FIFO_DEPTH`;
  - signals: push, pop, data in/out, full, empty, count.
- Address decode, the register file and the TX FSM live in `mmio_uart_tx`.

## Test plan
- **Reset:** `rst_n` = 0 → `tx` = 1. STATUS read returns 0x0000_0002 (empty). BAUDDIV reads 52.
- **Single byte:** BAUDDIV = 4, write 0x55 to +0 → `tx` = 0 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles. Busy reads 1 during the frame and 0 after.
- **Back-to-back:** write 0xA5 then 0x3C on consecutive cycles → two frames totalling exactly 80 cycles at DIV = 4, with no idle gap. STATUS count reads 1 after the first pop.
- **Overflow:**
  - With the FSM stalled, issue 10 writes into an empty FIFO → 1 pops, 8 are held, 1 is dropped. STATUS shows full and overflow.
  - Writing 0x8 to +4 clears overflow; the transmitted bytes are the first 9 in order.
- **Divisor clamp and mid-frame change:** write 0 to +8 → reads 2. Writing 10 during a frame leaves the current frame at 2-cycle bits; the next frame uses 10.
- **Reset mid-frame and decode:**
  - Assert `rst_n` during DATA → `tx` = 1 immediately; after release, STATUS shows empty.
  - A read outside the window returns 0.
